// File: rtl/instr_field_encoder_if.sv
// Handshake and bundle signals for the instruction field encoder.
// The slave side is the encoder; the master side drives bundles and consumes instructions.
interface instr_field_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             RegWrite;
  logic             ALUSrc;
  logic             MemWrite;
  logic             ResultSrc;
  logic             Branch;
  logic [2:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       tipo;
  logic [1:0]       op;
  logic             Inm;
  logic             illegal;
  logic [CNT_W-1:0] issued_count;
  logic [CNT_W-1:0] illegal_count;

  modport slave (
    input  in_valid, RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl, out_ready,
    output in_ready, out_valid, tipo, op, Inm, illegal, issued_count, illegal_count
  );

  modport master (
    output in_valid, RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl, out_ready,
    input  in_ready, out_valid, tipo, op, Inm, illegal, issued_count, illegal_count
  );
endinterface

// File: rtl/instr_field_encoder.sv
// Encodes a control-signal bundle back into {tipo, op, Inm} and issues it through a small FIFO.
// Illegal bundles are dropped, pulsed on illegal and counted with saturation.
module instr_field_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  instr_field_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  // Bundle layout: {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl[2:0]}.
  // Result layout: {legal, tipo[1:0], op[1:0], Inm}.
  function automatic logic [5:0] encode_bundle(input logic [7:0] b);
    logic [5:0] r;
    r = 6'b000000;
    casez (b)
      8'b1?000000: r = {1'b1, 2'b00, 2'b00, b[6]};
      8'b1?000001: r = {1'b1, 2'b00, 2'b01, b[6]};
      8'b11010000: r = {1'b1, 2'b01, 2'b01, 1'b0};
      8'b01100000: r = {1'b1, 2'b01, 2'b10, 1'b0};
      8'b0?001000: r = {1'b1, 2'b10, 2'b00, 1'b0};
      8'b0?000001: r = {1'b1, 2'b10, 2'b10, b[6]};
      default:     r = 6'b000000;
    endcase
    return r;
  endfunction

  logic [4:0]       mem_r [DEPTH];
  ptr_t             wr_ptr_r;
  ptr_t             rd_ptr_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             illegal_r;
  logic [4:0]       head_r;
  logic [CNT_W-1:0] issued_count_r;
  logic [CNT_W-1:0] illegal_count_r;

  logic [7:0] bundle_s;
  logic [5:0] enc_s;
  logic       accept_s;
  logic       push_s;
  logic       pop_s;
  ptr_t       wr_next_s;
  ptr_t       rd_next_s;
  logic       full_next_s;
  logic       empty_next_s;
  logic [4:0] head_next_s;

  assign bundle_s = {bus.RegWrite, bus.ALUSrc, bus.MemWrite, bus.ResultSrc, bus.Branch, bus.ALUControl};
  assign enc_s    = encode_bundle(bundle_s);
  assign accept_s = bus.in_valid && in_ready_r;
  assign push_s   = accept_s && enc_s[5];
  assign pop_s    = out_valid_r && bus.out_ready;

  // Next pointers, flags and the head value to present after this edge.
  always_comb begin
    wr_next_s    = push_s ? (wr_ptr_r + ptr_t'(1)) : wr_ptr_r;
    rd_next_s    = pop_s  ? (rd_ptr_r + ptr_t'(1)) : rd_ptr_r;
    full_next_s  = (wr_next_s[AW] != rd_next_s[AW]) && (wr_next_s[AW-1:0] == rd_next_s[AW-1:0]);
    empty_next_s = (wr_next_s == rd_next_s);
    head_next_s  = head_r;
    // The new head may be the entry being written this very cycle.
    if (empty_next_s) begin
      head_next_s = head_r;
    end else if (push_s && (rd_next_s == wr_ptr_r)) begin
      head_next_s = enc_s[4:0];
    end else begin
      head_next_s = mem_r[rd_next_s[AW-1:0]];
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r[AW-1:0]] <= enc_s[4:0];
    end
  end

  // Pointers, registered handshake flags, head register, pulse and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      in_ready_r      <= 1'b1;
      out_valid_r     <= 1'b0;
      illegal_r       <= 1'b0;
      head_r          <= 5'b00000;
      issued_count_r  <= '0;
      illegal_count_r <= '0;
    end else begin
      wr_ptr_r    <= wr_next_s;
      rd_ptr_r    <= rd_next_s;
      in_ready_r  <= !full_next_s;
      out_valid_r <= !empty_next_s;
      illegal_r   <= accept_s && !enc_s[5];
      head_r      <= head_next_s;
      if (pop_s) begin
        issued_count_r <= issued_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (accept_s && !enc_s[5] && (illegal_count_r != {CNT_W{1'b1}})) begin
        illegal_count_r <= illegal_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.in_ready      = in_ready_r;
  assign bus.out_valid     = out_valid_r;
  assign bus.tipo          = head_r[4:3];
  assign bus.op            = head_r[2:1];
  assign bus.Inm           = head_r[0];
  assign bus.illegal       = illegal_r;
  assign bus.issued_count  = issued_count_r;
  assign bus.illegal_count = illegal_count_r;
endmodule
